// File: rtl/ibex_rf_wport_arbiter.sv
// Register-file write-port arbiter.
// The pipeline writeback (P) has priority over a secondary long-latency
// requester (S). S writes that cannot go straight to the write port are
// held in a small in-order FIFO and drained into idle write-port cycles.
// A pending bitmap of buffered destinations lets ID detect read hazards.
// Optional build macro: IBEX_RF_ARB_FAIRNESS_EN (adds a starvation counter
// that forces a head drain after StarveLimit waiting cycles).
module ibex_rf_wport_arbiter #(
  parameter int unsigned DataWidth   = 32,
  parameter bit          RV32E       = 1'b0,
  parameter int unsigned FifoDepth   = 2,
  parameter int unsigned StarveLimit = 4,
  localparam int unsigned NumWords   = RV32E ? 16 : 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 p_we_i,
  input  logic [4:0]           p_waddr_i,
  input  logic [DataWidth-1:0] p_wdata_i,
  output logic                 p_ready_o,
  input  logic                 s_valid_i,
  input  logic [4:0]           s_waddr_i,
  input  logic [DataWidth-1:0] s_wdata_i,
  output logic                 s_ready_o,
  input  logic [4:0]           raddr_a_i,
  input  logic [4:0]           raddr_b_i,
  output logic                 hazard_a_o,
  output logic                 hazard_b_o,
  output logic [NumWords-1:0]  pending_o,
  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o
);

  localparam int unsigned AW   = RV32E ? 4 : 5;
  localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;

  logic [4:0]           addr_q [FifoDepth];
  logic [DataWidth-1:0] data_q [FifoDepth];
  logic [FifoDepth-1:0] valid_q;
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;

  logic                 fifo_empty, fifo_full;
  logic                 p_hazard, force_drain, s_is_x0;
  logic                 deq, enq, s_bypass;
  logic [4:0]           head_addr;
  logic [DataWidth-1:0] head_data;

  assign fifo_empty = (valid_q == '0);
  assign fifo_full  = &valid_q;
  assign head_addr  = addr_q[rd_ptr_q];
  assign head_data  = data_q[rd_ptr_q];
  assign s_is_x0    = (s_waddr_i[AW-1:0] == '0);
  assign s_ready_o  = ~fifo_full;

  // Pending bitmap: OR of the one-hot destinations of every valid entry.
  always_comb begin
    pending_o = '0;
    for (int i = 0; i < FifoDepth; i++) begin
      if (valid_q[i]) pending_o[addr_q[i][AW-1:0]] = 1'b1;
    end
  end

  assign hazard_a_o = pending_o[raddr_a_i[AW-1:0]] & (raddr_a_i[AW-1:0] != '0);
  assign hazard_b_o = pending_o[raddr_b_i[AW-1:0]] & (raddr_b_i[AW-1:0] != '0);
  assign p_hazard   = p_we_i & pending_o[p_waddr_i[AW-1:0]];

`ifdef IBEX_RF_ARB_FAIRNESS_EN
  localparam int unsigned CntW = $clog2(StarveLimit + 1);
  logic [CntW-1:0] starve_q;

  assign force_drain = ~fifo_empty & (starve_q == CntW'(StarveLimit));

  // Count cycles the head waits; saturate at the limit, clear on drain/empty.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_q <= '0;
    end else if (fifo_empty || deq) begin
      starve_q <= '0;
    end else if (starve_q != CntW'(StarveLimit)) begin
      starve_q <= starve_q + 1'b1;
    end
  end
`else
  assign force_drain = 1'b0;
`endif

  // Write-port grant: hazard/forced drain, then P, then FIFO head, then S bypass.
  always_comb begin
    rf_we_o    = 1'b0;
    rf_waddr_o = '0;
    rf_wdata_o = '0;
    p_ready_o  = 1'b1;
    deq        = 1'b0;
    s_bypass   = 1'b0;
    if (p_we_i && (p_hazard || force_drain)) begin
      // Older buffered write must land first; hold P until its bit clears.
      p_ready_o  = 1'b0;
      deq        = 1'b1;
      rf_we_o    = 1'b1;
      rf_waddr_o = head_addr;
      rf_wdata_o = head_data;
    end else if (p_we_i) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = p_waddr_i;
      rf_wdata_o = p_wdata_i;
    end else if (!fifo_empty) begin
      deq        = 1'b1;
      rf_we_o    = 1'b1;
      rf_waddr_o = head_addr;
      rf_wdata_o = head_data;
    end else if (s_valid_i && !s_is_x0) begin
      s_bypass   = 1'b1;
      rf_we_o    = 1'b1;
      rf_waddr_o = s_waddr_i;
      rf_wdata_o = s_wdata_i;
    end
  end

  // x0 writes are accepted and dropped; a full FIFO never passes S through.
  assign enq = s_valid_i & ~fifo_full & ~s_bypass & ~s_is_x0;

  // FIFO storage, valid bits and wrapping pointers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < FifoDepth; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (enq) begin
        addr_q[wr_ptr_q]  <= s_waddr_i;
        data_q[wr_ptr_q]  <= s_wdata_i;
        valid_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q <= (wr_ptr_q == PtrW'(FifoDepth - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (deq) begin
        valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q <= (rd_ptr_q == PtrW'(FifoDepth - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ibex_rf_wport_arbiter.sv
// Directed bench for ibex_rf_wport_arbiter (default parameters).
module tb_ibex_rf_wport_arbiter;

  logic        clk, rst_n;
  logic        p_we, p_ready, s_valid, s_ready;
  logic [4:0]  p_waddr, s_waddr, raddr_a, raddr_b, rf_waddr;
  logic [31:0] p_wdata, s_wdata, rf_wdata, pending;
  logic        hazard_a, hazard_b, rf_we;

  int vec;
  int errs;

  ibex_rf_wport_arbiter dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .p_we_i     (p_we),
    .p_waddr_i  (p_waddr),
    .p_wdata_i  (p_wdata),
    .p_ready_o  (p_ready),
    .s_valid_i  (s_valid),
    .s_waddr_i  (s_waddr),
    .s_wdata_i  (s_wdata),
    .s_ready_o  (s_ready),
    .raddr_a_i  (raddr_a),
    .raddr_b_i  (raddr_b),
    .hazard_a_o (hazard_a),
    .hazard_b_o (hazard_b),
    .pending_o  (pending),
    .rf_we_o    (rf_we),
    .rf_waddr_o (rf_waddr),
    .rf_wdata_o (rf_wdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    p_we = 0; p_waddr = 0; p_wdata = 0;
    s_valid = 0; s_waddr = 0; s_wdata = 0;
    raddr_a = 0; raddr_b = 0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    #3;
    vec++; if (rf_we !== 1'b0) begin errs++; $display("FAIL reset_rf_we got=%b exp=0", rf_we); end
    vec++; if (rf_waddr !== 5'd0) begin errs++; $display("FAIL reset_rf_waddr got=%0d exp=0", rf_waddr); end
    vec++; if (rf_wdata !== 32'd0) begin errs++; $display("FAIL reset_rf_wdata got=%h exp=0", rf_wdata); end
    vec++; if (s_ready !== 1'b1) begin errs++; $display("FAIL reset_s_ready got=%b exp=1", s_ready); end
    vec++; if (p_ready !== 1'b1) begin errs++; $display("FAIL reset_p_ready got=%b exp=1", p_ready); end
    vec++; if (pending !== 32'd0) begin errs++; $display("FAIL reset_pending got=%h exp=0", pending); end
    vec++; if ({hazard_a, hazard_b} !== 2'b00) begin errs++; $display("FAIL reset_hazard got=%b exp=00", {hazard_a, hazard_b}); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    step();
  endtask

  task automatic test_bypass();
    s_valid = 1; s_waddr = 5; s_wdata = 32'hA5A5A5A5;
    #2;
    vec++; if ({rf_we, rf_waddr} !== {1'b1, 5'd5}) begin errs++; $display("FAIL bypass_addr got=%b/%0d exp=1/5", rf_we, rf_waddr); end
    vec++; if (rf_wdata !== 32'hA5A5A5A5) begin errs++; $display("FAIL bypass_data got=%h exp=a5a5a5a5", rf_wdata); end
    vec++; if (s_ready !== 1'b1) begin errs++; $display("FAIL bypass_s_ready got=%b exp=1", s_ready); end
    step();
    idle();
    #2;
    vec++; if (pending !== 32'd0) begin errs++; $display("FAIL bypass_pending got=%h exp=0", pending); end
    vec++; if (rf_we !== 1'b0) begin errs++; $display("FAIL bypass_after_we got=%b exp=0", rf_we); end
    step();
  endtask

  task automatic test_buffering();
    p_we = 1; p_waddr = 3; p_wdata = 32'h33;
    s_valid = 1; s_waddr = 7; s_wdata = 32'h77;
    #2;
    vec++; if ({rf_we, rf_waddr, p_ready, s_ready} !== {1'b1, 5'd3, 1'b1, 1'b1}) begin errs++; $display("FAIL buf_c1 got=%b/%0d/%b/%b exp=1/3/1/1", rf_we, rf_waddr, p_ready, s_ready); end
    step();
    s_waddr = 9; s_wdata = 32'h99;
    #2;
    vec++; if (pending !== 32'h80) begin errs++; $display("FAIL buf_pending1 got=%h exp=80", pending); end
    vec++; if ({rf_waddr, s_ready} !== {5'd3, 1'b1}) begin errs++; $display("FAIL buf_c2 got=%0d/%b exp=3/1", rf_waddr, s_ready); end
    step();
    s_waddr = 11; s_wdata = 32'hBB;
    raddr_a = 7; raddr_b = 3;
    #2;
    vec++; if (pending !== 32'h280) begin errs++; $display("FAIL buf_pending2 got=%h exp=280", pending); end
    vec++; if ({hazard_a, hazard_b} !== 2'b10) begin errs++; $display("FAIL buf_hazard got=%b exp=10", {hazard_a, hazard_b}); end
    vec++; if (s_ready !== 1'b0) begin errs++; $display("FAIL buf_full_s_ready got=%b exp=0", s_ready); end
    raddr_b = 9;
    #1;
    vec++; if (hazard_b !== 1'b1) begin errs++; $display("FAIL buf_hazard_b9 got=%b exp=1", hazard_b); end
    step();
    #2;
    vec++; if ({pending, s_ready} !== {32'h280, 1'b0}) begin errs++; $display("FAIL buf_hold got=%h/%b exp=280/0", pending, s_ready); end
    p_we = 0; s_valid = 0;
    #1;
    vec++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd7, 32'h77}) begin errs++; $display("FAIL buf_drain7 got=%b/%0d/%h exp=1/7/77", rf_we, rf_waddr, rf_wdata); end
    step();
    s_valid = 1; s_waddr = 12; s_wdata = 32'hCC;
    #2;
    vec++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd9, 32'h99}) begin errs++; $display("FAIL buf_drain9 got=%b/%0d/%h exp=1/9/99", rf_we, rf_waddr, rf_wdata); end
    vec++; if ({pending, s_ready} !== {32'h200, 1'b1}) begin errs++; $display("FAIL buf_enq_deq got=%h/%b exp=200/1", pending, s_ready); end
    step();
    s_valid = 0;
    #2;
    vec++; if (pending !== 32'h1000) begin errs++; $display("FAIL buf_pending12 got=%h exp=1000", pending); end
    vec++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd12, 32'hCC}) begin errs++; $display("FAIL buf_drain12 got=%b/%0d/%h exp=1/12/cc", rf_we, rf_waddr, rf_wdata); end
    step();
    #2;
    vec++; if ({rf_we, pending} !== {1'b0, 32'h0}) begin errs++; $display("FAIL buf_empty got=%b/%h exp=0/0", rf_we, pending); end
    idle();
    step();
  endtask

  task automatic test_hazard_drain();
    p_we = 1; p_waddr = 1; p_wdata = 32'h01;
    s_valid = 1; s_waddr = 4; s_wdata = 32'h11;
    step();
    s_valid = 0;
    p_waddr = 4; p_wdata = 32'h22;
    #2;
    vec++; if (p_ready !== 1'b0) begin errs++; $display("FAIL haz_p_ready1 got=%b exp=0", p_ready); end
    vec++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd4, 32'h11}) begin errs++; $display("FAIL haz_old got=%b/%0d/%h exp=1/4/11", rf_we, rf_waddr, rf_wdata); end
    step();
    #2;
    vec++; if (p_ready !== 1'b1) begin errs++; $display("FAIL haz_p_ready2 got=%b exp=1", p_ready); end
    vec++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd4, 32'h22}) begin errs++; $display("FAIL haz_new got=%b/%0d/%h exp=1/4/22", rf_we, rf_waddr, rf_wdata); end
    vec++; if (pending !== 32'h0) begin errs++; $display("FAIL haz_pending got=%h exp=0", pending); end
    idle();
    step();
  endtask

  task automatic test_x0();
    s_valid = 1; s_waddr = 0; s_wdata = 32'hDEAD;
    #2;
    vec++; if ({s_ready, rf_we} !== 2'b10) begin errs++; $display("FAIL x0_empty got=%b/%b exp=1/0", s_ready, rf_we); end
    step();
    // x0 from S while P busy must not be buffered either
    p_we = 1; p_waddr = 2; p_wdata = 32'h2;
    #2;
    step();
    p_we = 0; s_valid = 0;
    #2;
    vec++; if ({rf_we, pending} !== {1'b0, 32'h0}) begin errs++; $display("FAIL x0_not_queued got=%b/%h exp=0/0", rf_we, pending); end
    p_we = 1; p_waddr = 0; p_wdata = 32'h5;
    #1;
    vec++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd0, 32'h5}) begin errs++; $display("FAIL x0_p_pass got=%b/%0d/%h exp=1/0/5", rf_we, rf_waddr, rf_wdata); end
    vec++; if (hazard_a !== 1'b0) begin errs++; $display("FAIL x0_hazard got=%b exp=0", hazard_a); end
    idle();
    step();
  endtask

  task automatic test_fairness();
    int drain_cyc;
`ifdef IBEX_RF_ARB_FAIRNESS_EN
    drain_cyc = 5;
`else
    drain_cyc = 0;
`endif
    p_we = 1; p_waddr = 3; p_wdata = 32'h33;
    s_valid = 1; s_waddr = 6; s_wdata = 32'h66;
    step();
    s_valid = 0;
    for (int c = 1; c <= 8; c++) begin
      #2;
      if (c == drain_cyc) begin
        vec++; if ({p_ready, rf_waddr, rf_wdata} !== {1'b0, 5'd6, 32'h66}) begin errs++; $display("FAIL fair_drain c=%0d got=%b/%0d/%h exp=0/6/66", c, p_ready, rf_waddr, rf_wdata); end
      end else begin
        vec++; if ({p_ready, rf_waddr} !== {1'b1, 5'd3}) begin errs++; $display("FAIL fair_p c=%0d got=%b/%0d exp=1/3", c, p_ready, rf_waddr); end
      end
      step();
    end
    p_we = 0;
    #2;
    if (drain_cyc != 0) begin
      vec++; if ({rf_we, pending} !== {1'b0, 32'h0}) begin errs++; $display("FAIL fair_after got=%b/%h exp=0/0", rf_we, pending); end
    end else begin
      vec++; if ({rf_we, rf_waddr, pending} !== {1'b1, 5'd6, 32'h40}) begin errs++; $display("FAIL fair_starved got=%b/%0d/%h exp=1/6/40", rf_we, rf_waddr, pending); end
    end
    idle();
    step();
  endtask

  task automatic test_reset_mid();
    p_we = 1; p_waddr = 2; p_wdata = 32'h2;
    s_valid = 1; s_waddr = 8; s_wdata = 32'h88;
    step();
    s_waddr = 10; s_wdata = 32'hAA;
    step();
    #2;
    vec++; if (pending !== 32'h500) begin errs++; $display("FAIL rmid_pre got=%h exp=500", pending); end
    idle();
    rst_n = 0;
    #1;
    vec++; if ({pending, s_ready, rf_we} !== {32'h0, 1'b1, 1'b0}) begin errs++; $display("FAIL rmid_in_reset got=%h/%b/%b exp=0/1/0", pending, s_ready, rf_we); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    step();
    #1;
    vec++; if ({rf_we, pending} !== {1'b0, 32'h0}) begin errs++; $display("FAIL rmid_after got=%b/%h exp=0/0", rf_we, pending); end
    step();
  endtask

  initial begin
    vec = 0;
    errs = 0;
    test_reset();
    test_bypass();
    test_buffering();
    test_hazard_drain();
    test_x0();
    test_fairness();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/ibex_rf_wport_arbiter.md
Name: ibex_rf_wport_arbiter

Overview:
Arbitrates the single register-file write port between the pipeline writeback (P, priority) and a secondary long-latency requester (S: late LSU response, multi-cycle unit, debug write).
- S writes that cannot be issued immediately are buffered in a small FIFO and drained into idle write-port cycles.
- Keeps a pending-write scoreboard so ID can detect read hazards on buffered destinations.
- Sits between the writeback stage and the register file write port W1.

Parameters:
DataWidth, 32, width of write data (includes ECC bits when enabled).
RV32E, 0, 1 = 16 architectural registers (address bits [3:0] used); 0 = 32 registers.
FifoDepth, 2, S buffer entries (>=1).
StarveLimit, 4, cycles a non-empty FIFO head may wait before forced drain (only with the optional feature).

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
p_we_i  in  1  pipeline writeback request
p_waddr_i  in  5  pipeline destination
p_wdata_i  in  DataWidth  pipeline data
p_ready_o  out  1  pipeline write accepted this cycle
s_valid_i  in  1  secondary request
s_waddr_i  in  5  secondary destination
s_wdata_i  in  DataWidth  secondary data
s_ready_o  out  1  secondary request accepted (valid&ready handshake)
raddr_a_i  in  5  ID read address A
raddr_b_i  in  5  ID read address B
hazard_a_o  out  1  raddr_a_i matches a buffered write
hazard_b_o  out  1  raddr_b_i matches a buffered write
pending_o  out  NUM_WORDS  bitmap of destinations held in the FIFO
rf_we_o  out  1  register-file write enable
rf_waddr_o  out  5  register-file write address
rf_wdata_o  out  DataWidth  register-file write data

Behaviour:
- Interface: one clock, clk_i. Reset rst_ni is asynchronous and active-low.
- Reset state:
  - FIFO empty; pending_o = 0; hazard_a_o = hazard_b_o = 0.
  - rf_we_o = 0; rf_waddr_o = 0; rf_wdata_o = 0.
  - s_ready_o = 1; p_ready_o = 1; starvation counter = 0.
- Write-port outputs are combinational. The register file provides the storage flop, so write latency is 0 cycles from grant.
- Addresses: NUM_WORDS = RV32E ? 16 : 32. Only the low log2(NUM_WORDS) bits are compared and used to index pending_o.
- x0 writes: an S request to address 0 is accepted (s_ready_o per normal rules) and discarded, never enqueued. P writes to x0 pass through unchanged.
- Per-cycle port grant, in priority order:
  1. Hazard drain: p_we_i=1 and the P address has its pending bit set. Set p_ready_o=0 and drain the FIFO head to the RF. Repeat until the bit clears, so the older S write lands before the younger P write.
  2. P write: p_we_i=1 with no hazard. Grant P; p_ready_o=1.
  3. FIFO drain: FIFO non-empty. Drain the head.
  4. S bypass: FIFO empty and s_valid_i=1. Write S directly; s_ready_o=1; no enqueue.
  5. Otherwise rf_we_o=0.
- s_ready_o = !full.
  - An accepted S request not written by bypass is enqueued at the tail.
  - Enqueue and dequeue in the same cycle are both honoured; occupancy is unchanged.
  - When full, there is no pass-through, even if the head drains that cycle.
- p_ready_o=1 whenever p_we_i=0.
- pending_o and hazard outputs:
  - pending_o = OR of one-hot decoded addresses of all valid entries. It updates the cycle after enqueue and clears the cycle after the last matching entry drains.
  - hazard_x_o = pending_o[raddr_x_i] and raddr_x_i != 0; purely combinational.
- FIFO order is strict; pointers wrap modulo FifoDepth.
- Reset mid-operation discards all buffered writes with no RF write.

Optional Feature:
Macro IBEX_RF_ARB_FAIRNESS_EN.
- Defined:
  - Starvation counter increments each cycle the FIFO is non-empty and the head is not drained; it resets to 0 on any drain or when the FIFO is empty.
  - When the counter == StarveLimit, the head drains with priority over a P write (p_ready_o=0 that cycle).
- Undefined: counter absent; P always wins except in the hazard-drain case; the FIFO may starve indefinitely.

Test Plan:
- Reset, no requests -> rf_we_o=0, s_ready_o=1, p_ready_o=1, pending_o=0.
- FIFO empty, P idle, S valid addr 5 data 0xA5A5A5A5 -> same cycle rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0xA5A5A5A5; pending_o stays 0.
- P writes x3 every cycle while S sends x7 then x9 -> both enqueued; pending_o=0x280; hazard_a_o=1 for raddr_a_i=7; third S request sees s_ready_o=0; P stops -> x7 then x9 written on consecutive cycles; pending_o=0 after.
- FIFO holds x4=0x11; P writes x4=0x22 -> cycle 1: p_ready_o=0, RF gets x4=0x11; cycle 2: p_ready_o=1, RF gets x4=0x22.
- S to x0 while FIFO empty -> s_ready_o=1, no RF write, pending_o unchanged.
- IBEX_RF_ARB_FAIRNESS_EN, StarveLimit=4, continuous P writes, one S entry -> on the 5th cycle p_ready_o=0 and the S entry drains; without the macro it never drains while P is active.
